// File: rtl/contadores_ram_if.sv
// Event/read bus of the counter bank: event strobe, address, clear/read controls
// and the registered total and read data coming back.
interface contadores_ram_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned CNT_W  = 4
);
    logic              write_enable;
    logic [ADDR_W-1:0] adress;
    logic              count_read;
    logic              count_reset;
    logic [ADDR_W-1:0] counter;
    logic [CNT_W-1:0]  count_out;

    // Event source side.
    modport master (
        output write_enable,
        output adress,
        output count_read,
        output count_reset,
        input  counter,
        input  count_out
    );

    // Counter bank side.
    modport slave (
        input  write_enable,
        input  adress,
        input  count_read,
        input  count_reset,
        output counter,
        output count_out
    );
endinterface

// File: rtl/contadores_ram.sv
// Bank of 2^ADDR_W event counters held in a register array, with a running
// total of increment events and a registered, write-first read port.
module contadores_ram #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned CNT_W  = 4
) (
    input  logic           clk,
    input  logic           gen_reset,
    contadores_ram_if.slave bus
);
    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [CNT_W-1:0]  mem_q [Depth];
    logic [ADDR_W-1:0] counter_q, counter_d;
    logic [CNT_W-1:0]  count_out_q, count_out_d;

    logic [CNT_W-1:0]  cur_val;
    logic [CNT_W-1:0]  wr_val;
    logic [CNT_W-1:0]  post_val;
    logic              is_incr;

    // Value the addressed entry takes after this edge's write action.
    always_comb begin
        cur_val  = mem_q[bus.adress];
        is_incr  = bus.write_enable & ~bus.count_reset;
        wr_val   = bus.count_reset ? '0 : cur_val + CNT_W'(1);
        post_val = bus.write_enable ? wr_val : cur_val;
    end

    // Next total and read data; a clear is not counted as an event.
    always_comb begin
        counter_d   = counter_q;
        count_out_d = count_out_q;
        if (is_incr) begin
            counter_d = counter_q + ADDR_W'(1);
        end
        if (bus.count_read) begin
            count_out_d = post_val;
        end
    end

    // Counter storage: global reset clears every entry, else one entry per cycle.
    always_ff @(posedge clk) begin
        if (gen_reset) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.write_enable) begin
            mem_q[bus.adress] <= wr_val;
        end
    end

    // Output registers for the event total and the read port.
    always_ff @(posedge clk) begin
        if (gen_reset) begin
            counter_q   <= '0;
            count_out_q <= '0;
        end else begin
            counter_q   <= counter_d;
            count_out_q <= count_out_d;
        end
    end

    assign bus.counter   = counter_q;
    assign bus.count_out = count_out_q;
endmodule

// File: tb/tb_contadores_ram.sv
// Self-checking bench for contadores_ram: directed steps from the test plan
// followed by randomized traffic checked against a behavioural model.
module tb_contadores_ram;
    localparam int AW    = 6;
    localparam int CW    = 4;
    localparam int DEPTH = 64;

    logic clk;
    logic gen_reset;

    contadores_ram_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

    contadores_ram #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk       (clk),
        .gen_reset (gen_reset),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: counts per address, total of events, last read.
    int model_mem [DEPTH];
    int model_total;
    int model_out;

    int n_cmp;
    int n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive, advance the model by the rules, then compare outputs.
    task automatic step(input logic rst, input logic we, input logic clr, input logic rd,
                        input int addr);
        gen_reset        = rst;
        bus.write_enable = we;
        bus.count_reset  = clr;
        bus.count_read   = rd;
        bus.adress       = addr[AW-1:0];
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
            model_total = 0;
            model_out   = 0;
        end else begin
            if (we && clr) begin
                model_mem[addr] = 0;
            end else if (we) begin
                model_mem[addr] = (model_mem[addr] + 1) % 16;
                model_total     = (model_total + 1) % 64;
            end
            if (rd) model_out = model_mem[addr];
        end
        #1;
        check("model_counter", 32'(bus.counter), 32'(model_total));
        check("model_count_out", 32'(bus.count_out), 32'(model_out));
    endtask

    int seq_addr [7];
    int seq_exp  [7];
    int r;

    initial begin
        n_cmp = 0;
        n_err = 0;
        seq_addr = '{1, 2, 4, 8, 1, 2, 2};
        seq_exp  = '{1, 1, 1, 1, 2, 2, 3};
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
        model_total = 0;
        model_out   = 0;

        // Reset and read of corner addresses.
        step(1, 0, 0, 0, 0);
        check("reset_counter", 32'(bus.counter), 32'd0);
        check("reset_count_out", 32'(bus.count_out), 32'd0);
        step(0, 0, 0, 1, 0);  check("rst_rd0", 32'(bus.count_out), 32'd0);
        step(0, 0, 0, 1, 1);  check("rst_rd1", 32'(bus.count_out), 32'd0);
        step(0, 0, 0, 1, 62); check("rst_rd62", 32'(bus.count_out), 32'd0);
        step(0, 0, 0, 1, 63); check("rst_rd63", 32'(bus.count_out), 32'd0);
        check("rst_total", 32'(bus.counter), 32'd0);

        // Mixed increments with same-cycle read-back.
        for (int i = 0; i < 7; i++) begin
            step(0, 1, 0, 1, seq_addr[i]);
            check("mixed_rd", 32'(bus.count_out), 32'(seq_exp[i]));
        end
        check("mixed_total", 32'(bus.counter), 32'd7);

        // Per-counter clear, total unchanged.
        step(0, 1, 1, 1, 2);
        check("clr_rd", 32'(bus.count_out), 32'd0);
        check("clr_total", 32'(bus.counter), 32'd7);
        step(0, 0, 0, 1, 1);
        check("clr_other", 32'(bus.count_out), 32'd2);

        // count_reset without write_enable does nothing.
        step(0, 0, 1, 1, 1);
        check("clr_alone", 32'(bus.count_out), 32'd2);

        // Per-counter wrap.
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 0, 1, 5);
            if (i == 15) check("wrap_15", 32'(bus.count_out), 32'd15);
            if (i == 16) check("wrap_16", 32'(bus.count_out), 32'd0);
        end

        // Total wrap from a fresh reset.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) begin
            step(0, 1, 0, 0, i);
            if (i == 62) check("total_63", 32'(bus.counter), 32'd63);
        end
        check("total_wrap", 32'(bus.counter), 32'd0);

        // Reset wins over a same-cycle write.
        step(0, 1, 0, 0, 3);
        step(0, 1, 0, 0, 10);
        step(1, 1, 0, 1, 3);
        check("rstprio_out", 32'(bus.count_out), 32'd0);
        check("rstprio_total", 32'(bus.counter), 32'd0);
        step(0, 0, 0, 1, 3);  check("rstprio_m3", 32'(bus.count_out), 32'd0);
        step(0, 0, 0, 1, 10); check("rstprio_m10", 32'(bus.count_out), 32'd0);

        // Idle reads and hold of count_out.
        step(0, 0, 0, 1, 62); check("idle62", 32'(bus.count_out), 32'd0);
        step(0, 0, 0, 1, 63); check("idle63", 32'(bus.count_out), 32'd0);
        step(0, 1, 0, 1, 7);  check("hold_load", 32'(bus.count_out), 32'd1);
        step(0, 0, 0, 0, 8);  check("hold_a8", 32'(bus.count_out), 32'd1);
        step(0, 0, 0, 0, 9);  check("hold_a9", 32'(bus.count_out), 32'd1);

        // Randomized traffic; a narrow address window forces collisions and wraps.
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            step(r < 3, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1,
                 (i % 2 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 63)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/contadores_ram.md
# contadores_ram

Bank of 2^ADDR_W independent event counters, each CNT_W bits wide and stored in a register-array RAM indexed by address. An event on an address increments that address's counter. A counter can be cleared individually, or the whole bank can be cleared. A running total of all increment events is kept alongside, and any counter can be read out through a registered port. It sits beside event sources that report an address per event, such as per-channel hit or error tallies.

## Interface
- ADDR_W, default 6: address width; the bank holds 2^ADDR_W counters; also the width of `counter`.
- CNT_W, default 4: width of each per-address counter and of `count_out`.

- clk  input  1  rising-edge clock; the only clock.
- gen_reset  input  1  global reset, synchronous, active-high: clears the entire bank and all outputs.
- write_enable  input  1  event strobe; one event per cycle in which it is high.
- adress  input  ADDR_W  counter index used for the event, the per-counter clear and the read.
- count_read  input  1  load `count_out` with the counter at `adress`.
- count_reset  input  1  with `write_enable`: clear the addressed counter instead of incrementing it.
- counter  output  ADDR_W  registered total of increment events since `gen_reset`.
- count_out  output  CNT_W  registered read data.

## Operation
- Storage: mem[0 .. 2^ADDR_W-1], each CNT_W bits.
- Priority at each rising edge: `gen_reset`, then the write actions, then the read.
- gen_reset=1:
  - all mem entries, `counter` and `count_out` become 0.
  - all other inputs are ignored that cycle.
- write_enable=1, count_reset=0:
  - mem[adress] <= mem[adress]+1, modulo 2^CNT_W (15 wraps to 0).
  - counter <= counter+1, modulo 2^ADDR_W (63 wraps to 0).
- write_enable=1, count_reset=1:
  - mem[adress] <= 0.
  - `counter` is unchanged; a clear is not an event.
- write_enable=0: mem and `counter` hold; `count_reset` alone has no effect.
- count_read=1:
  - count_out <= the value mem[adress] holds after this edge's write action (write-first bypass).
  - A read in the same cycle as an increment returns the incremented value; a read with a clear returns 0.
- count_read=0: `count_out` holds its last value.
- `adress` is fully decoded; every value 0 .. 2^ADDR_W-1 is valid and there is no out-of-range case.

## Timing
- All state changes occur on the rising edge of `clk`; no asynchronous paths.
- Reset values: every mem entry 0, counter=0, count_out=0.
- Write latency: 1 cycle. mem reflects an event at the edge that samples `write_enable`.
- Read latency: 1 cycle. `count_out` is valid after the edge that samples `count_read`, with the same-edge write already included.
- Back-to-back events to the same address on consecutive cycles each count; there is no lost update.
- `gen_reset` asserted mid-sequence wins that cycle; events sampled at the same edge are discarded.
- Total throughput: one event or clear per cycle.

## Test plan
- Reset check: pulse `gen_reset` for 1 cycle, then read addresses 0, 1, 62 and 63 -> `count_out`=0 for each and `counter`=0.
- Mixed increments with read-back:
  - Stimulus: one 1-cycle write each, with `count_read`=1, to addresses 1, 2, 4, 8, 1, 2, 2.
  - Required: `count_out` after each write is 1, 1, 1, 1, 2, 2, 3.
  - Required: `counter`=7 at the end.
- Per-counter clear: `write_enable`=1, `count_reset`=1, `adress`=2, `count_read`=1 -> count_out=0 and counter stays 7. Then read address 1 -> 2.
- Counter wrap: 16 writes to address 5 -> `count_out`=0 after the 16th and 15 after the 15th.
- Total wrap: 64 increments spread over addresses -> `counter` returns to 0.
- Reset priority: assert `gen_reset` together with a write to address 3 -> mem[3]=0 and counter=0. Other addresses are also cleared.
- Idle read and hold:
  - Reading untouched addresses 62 and 63 returns 0.
  - Deasserting `count_read` keeps `count_out` unchanged while `adress` changes.
